mouse_cfg_sequencer: RTL and testbench

- Configures and positions the PS/2 mouse core (MouseCtl) through its value/setx/sety/setmax_x/setmax_y load interface.
- After reset, loads the screen bounds (1024x768 playfield) and centres the cursor.
- Afterwards, serves game-side "recenter" and "warp to (x,y)" requests one at a time, spacing each load strobe by a fixed gap.
- Sits beside the mouse core in the clk100MHz domain. Game requests arriving from clk75MHz are synchronised upstream, outside this block.

---
 rtl/mouse_pkg.sv | 31 +++
 rtl/mouse_cfg_timer.sv | 33 +++
 rtl/mouse_cfg_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mouse_cfg_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse configuration sequencer.
//   state_t : sequencer states (the GAP state is shared and returns to a stored state)
//   coord_t : 12-bit coordinate / load value as seen by the mouse core
//   SCREEN_* : default playfield bounds (1024x768) and cursor centre
package mouse_pkg;

  typedef logic [11:0] coord_t;

  typedef enum logic [2:0] {
    INIT_WAIT,
    LD_MAXX,
    LD_MAXY,
    LD_X,
    LD_Y,
    GAP,
    IDLE
  } state_t;

  localparam coord_t SCREEN_MAX_X    = 12'd1023;
  localparam coord_t SCREEN_MAX_Y    = 12'd767;
  localparam coord_t SCREEN_CENTER_X = 12'd512;
  localparam coord_t SCREEN_CENTER_Y = 12'd384;

  localparam int TMR_W = 16;

  // Unsigned saturation of a requested coordinate to its bound.
  function automatic coord_t clamp(input coord_t v, input coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_cfg_timer.sv
// Loadable down-counter with a terminal-count flag.
//   clk_i, rst_i : clock, synchronous active-high reset (counter takes RST_VAL)
//   load_i       : load load_val_i this cycle (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one, saturating at zero
//   done_o       : counter is zero
module mouse_cfg_timer #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mouse_cfg_sequencer.sv
// Drives the MouseCtl load interface: after reset loads the x/y bounds and centres
// the cursor, then serves recenter / warp requests one sequence at a time.
//   clk100MHz, rst          : clock, synchronous active-high reset
//   recenter_req, warp_req  : one-cycle request pulses (already synchronised)
//   warp_x, warp_y          : warp target, sampled with warp_req
//   value, setmax_x/y, setx/y : registered load data and one-hot load strobes
//   busy, cfg_done, seq_done  : sequence status
//
// state     | meaning
// INIT_WAIT | post-reset settle time before the first load
// LD_MAXX   | strobe setmax_x with the x bound
// LD_MAXY   | strobe setmax_y with the y bound
// LD_X      | strobe setx with the target x
// LD_Y      | strobe sety with the target y
// GAP       | strobe spacing; then continues at ret_q
// IDLE      | waiting for a request
module mouse_cfg_sequencer
  import mouse_pkg::*;
#(
  parameter coord_t      MAX_X       = SCREEN_MAX_X,
  parameter coord_t      MAX_Y       = SCREEN_MAX_Y,
  parameter coord_t      CENTER_X    = SCREEN_CENTER_X,
  parameter coord_t      CENTER_Y    = SCREEN_CENTER_Y,
  parameter int unsigned INIT_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        recenter_req,
  input  logic        warp_req,
  input  logic [11:0] warp_x,
  input  logic [11:0] warp_y,
  output logic [11:0] value,
  output logic        setmax_x,
  output logic        setmax_y,
  output logic        setx,
  output logic        sety,
  output logic        busy,
  output logic        cfg_done,
  output logic        seq_done
);

  // Reset loads INIT_CYCLES and the state only leaves INIT_WAIT once the count
  // has reached zero, so the first strobe lands INIT_CYCLES+1 cycles after release.
  // A GAP is entered with GAP_CYCLES-1 so it lasts exactly GAP_CYCLES cycles.
  localparam logic [TMR_W-1:0] INIT_LOAD = TMR_W'(INIT_CYCLES);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  state_t state_q, state_d, ret_q, ret_d;
  logic   rec_pend_q, rec_pend_d, warp_pend_q, warp_pend_d;
  coord_t wx_q, wx_d, wy_q, wy_d, tx_q, tx_d, ty_q, ty_d;
  coord_t value_q, value_d, req_x, req_y;
  logic   setmax_x_q, setmax_y_q, setx_q, sety_q;
  logic   busy_q, cfg_done_q, seq_done_q, seq_done_d;
  logic   tmr_load, tmr_dec, tmr_done;
  logic   any_req, sel_rec, start_seq;

  mouse_cfg_timer #(
    .W       (TMR_W),
    .RST_VAL (INIT_LOAD)
  ) u_timer (
    .clk_i      (clk100MHz),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  assign req_x   = clamp(warp_x, MAX_X);
  assign req_y   = clamp(warp_y, MAX_Y);
  // Same-cycle requests count as pending so IDLE and the final GAP can start at once.
  assign any_req = rec_pend_q | warp_pend_q | recenter_req | warp_req;
  assign sel_rec = rec_pend_q | recenter_req;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    start_seq  = 1'b0;
    seq_done_d = 1'b0;

    case (state_q)
      INIT_WAIT: begin
        if (tmr_done) state_d = LD_MAXX;
        else          tmr_dec = 1'b1;
      end
      LD_MAXX: begin state_d = GAP; ret_d = LD_MAXY; tmr_load = 1'b1; end
      LD_MAXY: begin state_d = GAP; ret_d = LD_X;    tmr_load = 1'b1; end
      LD_X:    begin state_d = GAP; ret_d = LD_Y;    tmr_load = 1'b1; end
      LD_Y:    begin state_d = GAP; ret_d = IDLE;    tmr_load = 1'b1; end
      GAP: begin
        if (!tmr_done) begin
          tmr_dec = 1'b1;
        end else if (ret_q == IDLE) begin
          seq_done_d = 1'b1;
          // Back-to-back sequences skip IDLE so busy never drops in between.
          if (any_req) begin
            state_d   = LD_X;
            start_seq = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = ret_q;
        end
      end
      IDLE: begin
        if (any_req) begin
          state_d   = LD_X;
          start_seq = 1'b1;
        end
      end
      default: state_d = INIT_WAIT;
    endcase

    rec_pend_d  = rec_pend_q | recenter_req;
    warp_pend_d = warp_pend_q | warp_req;
    wx_d        = warp_req ? req_x : wx_q;
    wy_d        = warp_req ? req_y : wy_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    if (start_seq) begin
      if (sel_rec) begin
        rec_pend_d = 1'b0;
        tx_d       = CENTER_X;
        ty_d       = CENTER_Y;
      end else begin
        warp_pend_d = 1'b0;
        tx_d        = wx_d;
        ty_d        = wy_d;
      end
    end

    value_d = value_q;
    case (state_d)
      LD_MAXX: value_d = MAX_X;
      LD_MAXY: value_d = MAX_Y;
      LD_X:    value_d = tx_d;
      LD_Y:    value_d = ty_q;
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state_q     <= INIT_WAIT;
      ret_q       <= LD_MAXY;
      rec_pend_q  <= 1'b0;
      warp_pend_q <= 1'b0;
      wx_q        <= '0;
      wy_q        <= '0;
      tx_q        <= CENTER_X;
      ty_q        <= CENTER_Y;
      value_q     <= '0;
      setmax_x_q  <= 1'b0;
      setmax_y_q  <= 1'b0;
      setx_q      <= 1'b0;
      sety_q      <= 1'b0;
      busy_q      <= 1'b1;
      cfg_done_q  <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      rec_pend_q  <= rec_pend_d;
      warp_pend_q <= warp_pend_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      value_q     <= value_d;
      setmax_x_q  <= (state_d == LD_MAXX);
      setmax_y_q  <= (state_d == LD_MAXY);
      setx_q      <= (state_d == LD_X);
      sety_q      <= (state_d == LD_Y);
      busy_q      <= (state_d != IDLE);
      cfg_done_q  <= cfg_done_q | seq_done_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign value    = value_q;
  assign setmax_x = setmax_x_q;
  assign setmax_y = setmax_y_q;
  assign setx     = setx_q;
  assign sety     = sety_q;
  assign busy     = busy_q;
  assign cfg_done = cfg_done_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_mouse_cfg_sequencer.sv
module tb_mouse_cfg_sequencer;

  localparam int INIT_C = 8;
  localparam int GAP_C  = 2;
  localparam int MX = 1023, MY = 767, CX = 512, CY = 384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recenter_req = 1'b0, warp_req = 1'b0;
  logic [11:0] warp_x = '0, warp_y = '0;
  logic [11:0] value;
  logic        setmax_x, setmax_y, setx, sety, busy, cfg_done, seq_done;

  mouse_cfg_sequencer #(
    .INIT_CYCLES (INIT_C),
    .GAP_CYCLES  (GAP_C)
  ) dut (
    .clk100MHz    (clk),
    .rst          (rst),
    .recenter_req (recenter_req),
    .warp_req     (warp_req),
    .warp_x       (warp_x),
    .warp_y       (warp_y),
    .value        (value),
    .setmax_x     (setmax_x),
    .setmax_y     (setmax_y),
    .setx         (setx),
    .sety         (sety),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .seq_done     (seq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0, n_fail = 0, obs_done = 0;

  // Reference model: a schedule of expected events keyed by cycle number.
  logic [3:0]  exp_vec  [int];   // {setmax_x, setmax_y, setx, sety}
  logic [11:0] exp_val  [int];
  bit          exp_done [int];
  int          free_time = 1 << 30;
  int          cfg_from  = 1 << 30;
  logic [11:0] exp_value_cur = '0;
  bit          rpend = 0, wpend = 0;
  int          mwx = 0, mwy = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic sched(input int t, input logic [3:0] v, input int val);
    exp_vec[t] = v;
    exp_val[t] = 12'(val);
  endtask

  task automatic model_init(input int r);
    int t;
    exp_vec.delete(); exp_val.delete(); exp_done.delete();
    rpend = 0; wpend = 0;
    t = r + INIT_C + 1;
    sched(t, 4'b1000, MX); t += GAP_C + 1;
    sched(t, 4'b0100, MY); t += GAP_C + 1;
    sched(t, 4'b0010, CX); t += GAP_C + 1;
    sched(t, 4'b0001, CY); t += GAP_C + 1;
    exp_done[t] = 1;
    free_time = t;
    cfg_from  = t;
  endtask

  // Request presented during cycle c; a sequence may start at c+1 once the
  // previous one has finished (its seq_done cycle).
  task automatic model_req(input int c, input bit rq, input bit wq, input int x, input int y);
    int s, tx, ty;
    if (wq) begin wpend = 1; mwx = imin(x, MX); mwy = imin(y, MY); end
    if (rq) rpend = 1;
    if ((c + 1 >= free_time) && (rpend || wpend)) begin
      s = c + 1;
      if (rpend) begin tx = CX; ty = CY; rpend = 0; end
      else       begin tx = mwx; ty = mwy; wpend = 0; end
      sched(s, 4'b0010, tx);
      sched(s + GAP_C + 1, 4'b0001, ty);
      exp_done[s + 2*GAP_C + 2] = 1;
      free_time = s + 2*GAP_C + 2;
    end
  endtask

  task automatic check_cycle(input bit in_rst);
    logic [3:0] ev;
    if (seq_done) obs_done++;
    if (in_rst) begin
      exp_value_cur = '0;
      chk("rst_strobes", 32'({setmax_x, setmax_y, setx, sety}), 32'd0);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_cfg_done", 32'(cfg_done), 32'd0);
      chk("rst_seq_done", 32'(seq_done), 32'd0);
    end else begin
      ev = exp_vec.exists(cyc) ? exp_vec[cyc] : 4'b0000;
      if (ev != 4'b0000) exp_value_cur = exp_val[cyc];
      chk("strobes", 32'({setmax_x, setmax_y, setx, sety}), 32'(ev));
      chk("value", 32'(value), 32'(exp_value_cur));
      chk("seq_done", 32'(seq_done), 32'(exp_done.exists(cyc)));
      chk("busy", 32'(busy), 32'(cyc < free_time));
      chk("cfg_done", 32'(cfg_done), 32'(cyc >= cfg_from));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; recenter_req = 1'b0; warp_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      check_cycle(1'b1);
    end
    rst = 1'b0;
    model_init(cyc);
  endtask

  task automatic step(input bit rq, input bit wq, input int x, input int y);
    recenter_req = rq; warp_req = wq; warp_x = 12'(x); warp_y = 12'(y);
    model_req(cyc, rq, wq, x, y);
    @(posedge clk); cyc++;
    @(negedge clk);
    recenter_req = 1'b0; warp_req = 1'b0;
    check_cycle(1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int d0, r0;
    @(negedge clk);
    // Plain init.
    do_reset(3);
    r0 = cyc;
    idle(INIT_C + 1);
    chk("init_setmax_x", 32'({setmax_x, value}), 32'({1'b1, 12'd1023}));
    idle(25 - INIT_C - 1);

    // Warp from IDLE, then a clamped warp.
    step(1'b0, 1'b1, 100, 200);
    chk("warp_setx_latency", 32'({setx, value}), 32'({1'b1, 12'd100}));
    idle(10);
    step(1'b0, 1'b1, 4000, 800);
    idle(10);

    // Simultaneous recenter and warp.
    d0 = obs_done;
    step(1'b1, 1'b1, 10, 20);
    idle(16);
    chk("contention_seq_done_count", 32'(obs_done - d0), 32'd2);

    // Two warps during INIT_WAIT: only the latest runs.
    do_reset(2);
    idle(2);
    step(1'b0, 1'b1, 5, 5);
    idle(2);
    step(1'b0, 1'b1, 7, 9);
    d0 = obs_done;
    idle(35);
    chk("init_plus_warp_done_count", 32'(obs_done - d0), 32'd2);

    // Reset right after setmax_y, then a full init again.
    do_reset(1);
    r0 = cyc;
    idle(INIT_C + 1 + GAP_C + 1);
    chk("pre_reset_setmax_y", 32'(setmax_y), 32'd1);
    idle(1);
    do_reset(1);
    idle(30);

    // Randomized requests, with coordinates biased around the bounds.
    for (int i = 0; i < 800; i++) begin
      bit rq, wq;
      int x, y;
      rq = ($urandom_range(0, 11) == 0);
      wq = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) begin
        x = $urandom_range(0, 4095); y = $urandom_range(0, 4095);
      end else begin
        x = $urandom_range(1019, 1027); y = $urandom_range(763, 771);
      end
      step(rq, wq, x, y);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
